// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard control slice.
// Optional statistics counters are enabled with the FWD_HAZARD_STATS_EN macro
// (see fwd_hazard_ctrl.sv); the package itself is macro-independent.
package fwd_pkg;

    // Register-index width carried in the in-flight stage tags.
    localparam int TAG_RD_W = 5;

    // Operand mux select encoding, shared with the downstream EX operand mux.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Destination tag of one in-flight instruction.
    typedef struct packed {
        logic                valid;
        logic [TAG_RD_W-1:0] rd;
        logic                reg_write;
        logic                mem_read;
    } stage_tag_t;

    // An empty pipeline slot: never a writer, never a load.
    localparam stage_tag_t TAG_BUBBLE = '0;

    // Saturating 32-bit accumulate used by the statistics counters.
    function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                            input logic [1:0]  inc);
        logic [32:0] sum;
        sum = {1'b0, cnt} + {31'b0, inc};
        sat_add = sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/fwd_sel_gen.sv
// Per-operand forwarding select and load-use match logic.
// Purely combinational; the top instantiates one copy for rs1 and one for rs2.
module fwd_sel_gen
    import fwd_pkg::*;
#(
    parameter int                    REG_ADDR_W = TAG_RD_W,
    parameter logic [REG_ADDR_W-1:0] ZERO_REG   = '0
) (
    input  logic                  use_rs,
    input  logic [REG_ADDR_W-1:0] rs,
    input  stage_tag_t            ex_tag,
    input  stage_tag_t            mem_tag,
    output logic [1:0]            sel_next,
    output logic                  load_hit
);

    logic ex_writer;
    logic mem_writer;
    logic ex_match;
    logic mem_match;

    // A stage only counts as a producer if it is live, writes, and its
    // destination is not the hard-wired zero register.
    assign ex_writer  = ex_tag.valid  & ex_tag.reg_write  & (ex_tag.rd  != ZERO_REG);
    assign mem_writer = mem_tag.valid & mem_tag.reg_write & (mem_tag.rd != ZERO_REG);

    assign ex_match  = use_rs & ex_writer  & (rs == ex_tag.rd);
    assign mem_match = use_rs & mem_writer & (rs == mem_tag.rd);

    // Youngest producer wins: the instruction now in EX will be in MEM when the
    // consumer reaches EX, so it maps to the EX/MEM result; the one in MEM maps
    // to the writeback value.
    always_comb begin
        sel_next = FWD_RF;
        if (ex_match) begin
            sel_next = FWD_MEM;
        end else if (mem_match) begin
            sel_next = FWD_WB;
        end
    end

    // A load in EX cannot forward in time; flag it so the top can stall.
    always_comb begin
        load_hit = ex_match & ex_tag.mem_read;
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard control for the EX-stage operand muxes.
// Tracks destination tags of EX/MEM/WB, registers the operand selects so they
// line up with the instruction in EX, raises a combinational load-use stall and
// inserts EX bubbles for stalls, flushes and empty ID slots.
// Optional: define FWD_HAZARD_STATS_EN to add saturating 32-bit counters
// stat_stalls, stat_fwd_mem and stat_fwd_wb.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int                    REG_ADDR_W = TAG_RD_W,
    parameter logic [REG_ADDR_W-1:0] ZERO_REG   = '0
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic                  stall,
    output logic                  ex_bubble
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0]           stat_stalls,
    output logic [31:0]           stat_fwd_mem,
    output logic [31:0]           stat_fwd_wb
`endif
);

    // Tag pipeline. The width of the rd field is fixed by the package, so
    // REG_ADDR_W is expected to stay equal to TAG_RD_W.
    stage_tag_t ex_q,  ex_d;
    stage_tag_t mem_q, mem_d;
    stage_tag_t wb_q,  wb_d;

    logic [1:0] sel_a_q, sel_a_d;
    logic [1:0] sel_b_q, sel_b_d;
    logic       bubble_q, bubble_d;

    logic [1:0] next_sel_a;
    logic [1:0] next_sel_b;
    logic       load_hit_a;
    logic       load_hit_b;
    logic       advance;

    fwd_sel_gen #(
        .REG_ADDR_W (REG_ADDR_W),
        .ZERO_REG   (ZERO_REG)
    ) u_sel_a (
        .use_rs   (id_use_rs1),
        .rs       (id_rs1),
        .ex_tag   (ex_q),
        .mem_tag  (mem_q),
        .sel_next (next_sel_a),
        .load_hit (load_hit_a)
    );

    fwd_sel_gen #(
        .REG_ADDR_W (REG_ADDR_W),
        .ZERO_REG   (ZERO_REG)
    ) u_sel_b (
        .use_rs   (id_use_rs2),
        .rs       (id_rs2),
        .ex_tag   (ex_q),
        .mem_tag  (mem_q),
        .sel_next (next_sel_b),
        .load_hit (load_hit_b)
    );

    // Load-use stall: a real instruction in ID reads the rd of a load in EX.
    // Still raised alongside a flush; IF/ID is refetched then, so it is harmless.
    assign stall = id_valid & (load_hit_a | load_hit_b);

    // Next-state of the tag pipeline and registered selects. Anything that
    // keeps the ID instruction out of EX turns EX into a bubble with RF selects,
    // while older stages keep draining.
    always_comb begin
        advance  = id_valid & ~stall & ~flush;
        ex_d     = TAG_BUBBLE;
        mem_d    = ex_q;
        wb_d     = mem_q;
        sel_a_d  = FWD_RF;
        sel_b_d  = FWD_RF;
        bubble_d = 1'b1;
        if (advance) begin
            ex_d.valid     = 1'b1;
            ex_d.rd        = id_rd;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            sel_a_d        = next_sel_a;
            sel_b_d        = next_sel_b;
            bubble_d       = 1'b0;
        end
    end

    // Pipeline registers; reset discards every in-flight tag at once.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ex_q     <= TAG_BUBBLE;
            mem_q    <= TAG_BUBBLE;
            wb_q     <= TAG_BUBBLE;
            sel_a_q  <= FWD_RF;
            sel_b_q  <= FWD_RF;
            bubble_q <= 1'b1;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            sel_a_q  <= sel_a_d;
            sel_b_q  <= sel_b_d;
            bubble_q <= bubble_d;
        end
    end

    assign fwd_sel_a = sel_a_q;
    assign fwd_sel_b = sel_b_q;
    assign ex_bubble = bubble_q;

`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] stat_stalls_q,  stat_stalls_d;
    logic [31:0] stat_fwd_mem_q, stat_fwd_mem_d;
    logic [31:0] stat_fwd_wb_q,  stat_fwd_wb_d;
    logic [1:0]  mem_hits;
    logic [1:0]  wb_hits;

    // Counters advance with the selects being registered this edge; operands
    // A and B are counted separately.
    always_comb begin
        mem_hits       = {1'b0, sel_a_d == FWD_MEM} + {1'b0, sel_b_d == FWD_MEM};
        wb_hits        = {1'b0, sel_a_d == FWD_WB}  + {1'b0, sel_b_d == FWD_WB};
        stat_stalls_d  = sat_add(stat_stalls_q,  {1'b0, stall});
        stat_fwd_mem_d = sat_add(stat_fwd_mem_q, mem_hits);
        stat_fwd_wb_d  = sat_add(stat_fwd_wb_q,  wb_hits);
    end

    // Statistics registers, cleared by reset and saturating at all-ones.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stat_stalls_q  <= '0;
            stat_fwd_mem_q <= '0;
            stat_fwd_wb_q  <= '0;
        end else begin
            stat_stalls_q  <= stat_stalls_d;
            stat_fwd_mem_q <= stat_fwd_mem_d;
            stat_fwd_wb_q  <= stat_fwd_wb_d;
        end
    end

    assign stat_stalls  = stat_stalls_q;
    assign stat_fwd_mem = stat_fwd_mem_q;
    assign stat_fwd_wb  = stat_fwd_wb_q;
`endif

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Pipeline control block that sits directly upstream of the EX-stage 3-input operand muxes.
- Tracks destination-register tags of in-flight instructions (EX, MEM, WB) and produces registered 2-bit forwarding selects for ALU operands A and B, timed to the EX cycle.
- Detects load-use hazards and issues a one-cycle stall plus an EX bubble.
- Also handles branch flush bubbles.

Parameters:
- REG_ADDR_W, 5, register-index width.
- ZERO_REG, 0, index of the hard-wired zero register; it never matches for forwarding or hazards.

Ports:
- clk  in  1  pipeline clock, rising edge.
- arst  in  1  asynchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_ADDR_W  source register 1 of the instruction in ID.
- id_rs2  in  REG_ADDR_W  source register 2 of the instruction in ID.
- id_use_rs1  in  1  instruction reads rs1.
- id_use_rs2  in  1  instruction reads rs2.
- id_rd  in  REG_ADDR_W  destination of the instruction in ID.
- id_reg_write  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- flush  in  1  branch taken; squash the instruction in ID.
- fwd_sel_a  out  2  operand A select during EX; same encoding as the select input of the downstream operand mux.
- fwd_sel_b  out  2  operand B select during EX; same encoding as the select input of the downstream operand mux.
- stall  out  1  hold PC and IF/ID this cycle; combinational.
- ex_bubble  out  1  EX holds a bubble (registered).

Behaviour:
- Select encoding:
  - 2'b00 = register-file value.
  - 2'b10 = EX/MEM ALU result.
  - 2'b01 = MEM/WB writeback value.
  - 2'b11 is never driven.
- Internal tag pipeline, each stage holding {valid, rd, reg_write, mem_read}: ex_q, mem_q, wb_q. wb_q is kept for debug and counters.
- Qualified writer at stage S: S.valid & S.reg_write & (S.rd != ZERO_REG).
- Load-use stall (combinational):
  - stall = id_valid & ex_q.valid & ex_q.mem_read & ex_q.reg_write & ex_q.rd != ZERO_REG & ((id_use_rs1 & id_rs1 == ex_q.rd) | (id_use_rs2 & id_rs2 == ex_q.rd)).
- Next-select per operand X in {rs1→a, rs2→b}, only when id_use_X, else 00. Evaluated against the current ex_q/mem_q:
  - if ex_q is a qualified writer and ex_q.rd == id_X → 10 (it will be in MEM next cycle);
  - else if mem_q is a qualified writer and mem_q.rd == id_X → 01;
  - else 00.
  - ex_q has priority over mem_q (youngest wins).
- Clock edge, normal case: ex_q <= ID fields; mem_q <= ex_q; wb_q <= mem_q; fwd_sel_a/b <= next-select.
- Clock edge, stall, flush, or !id_valid:
  - ex_q.valid <= 0 and fwd_sel_a/b <= 00 (bubble); ex_bubble <= 1.
  - mem_q and wb_q still advance.
- After a load-use stall, the load sits in mem_q, so the re-evaluated consumer gets 01.
- flush and stall in the same cycle: flush wins the bubble; stall output is still driven, which is harmless because IF/ID is refetched.
- Latency: selects are registered, 1 cycle after ID evaluation, aligned with the instruction in EX.
- Reset (async, arst=1):
  - all stage valids = 0;
  - fwd_sel_a = fwd_sel_b = 2'b00;
  - ex_bubble = 1;
  - stall = 0, since no valid EX.
- Reset mid-operation: all in-flight tags are discarded immediately; the first post-reset instruction sees no forwarding.

Optional Feature:
- Macro FWD_HAZARD_STATS_EN.
- When defined, adds three 32-bit output counters, reset to 0, that saturate at all-ones:
  - stat_stalls increments each cycle stall=1;
  - stat_fwd_mem increments per registered select equal to 10 (a and b counted separately);
  - stat_fwd_wb likewise for 01.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package fwd_pkg holds:
  - localparams FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01;
  - a packed struct type for the stage tag {valid, rd, reg_write, mem_read}.
- One natural sub-module: fwd_sel_gen, the combinational per-operand select and hazard-match logic, instantiated twice (rs1, rs2).

Test Plan:
- add x5 ← ..., then next instr add x6, x5, x1 (use_rs1): second instr in EX → fwd_sel_a=10, fwd_sel_b=00, stall never 1.
- add x5; nop; sub x7, x2, x5: sub in EX → fwd_sel_b=01.
- add x5 then add x5 then use x5: youngest wins → 10.
- lw x8 ← ...; add x9, x8, x8:
  - stall=1 for exactly 1 cycle, ex_bubble=1 the following cycle;
  - add then reaches EX with fwd_sel_a=fwd_sel_b=01.
- Writer to x0 followed by a reader of x0 → selects 00, no stall.
- Same for id_use_rs2=0 with rs2 matching a load rd → no stall.
- Assert arst while a load is in EX with a dependent instruction in ID:
  - outputs immediately 00/0, ex_bubble=1;
  - after release, the dependent instruction is re-presented → no stall, selects 00.
- With FWD_HAZARD_STATS_EN: the load-use sequence gives stat_stalls=1 and stat_fwd_wb=2.
